// File: rtl/lvm_pkg.sv
// -----------------------------------------------------------------------------
// lvm_pkg : shared types and constants for the pc_unit16 slice.
//   LVM_WIDTH      - default address/data word width
//   word_t         - LVM_WIDTH-bit word
//   LVM_RESET_VEC  - default reset vector for the program counter
//   pc_op_e        - per-cycle pc operation chosen by the priority decoder
//   pc_decode()    - ret > call > load > inc > hold; call/ret are ignored
//                    when the return stack is not built
// -----------------------------------------------------------------------------
package lvm_pkg;

   localparam int LVM_WIDTH = 16;

   typedef logic [LVM_WIDTH-1:0] word_t;

   localparam word_t LVM_RESET_VEC = 16'h0000;

   typedef enum logic [2:0] {
      PC_HOLD,
      PC_INC,
      PC_LOAD,
      PC_CALL,
      PC_RET
   } pc_op_e;

   function automatic pc_op_e pc_decode(input logic ret, input logic call,
                                        input logic load, input logic inc,
                                        input bit stk_en);
      pc_op_e op;
      op = PC_HOLD;
      if (stk_en && ret)       op = PC_RET;
      else if (stk_en && call) op = PC_CALL;
      else if (load)           op = PC_LOAD;
      else if (inc)            op = PC_INC;
      return op;
   endfunction

endpackage

// File: rtl/pc_unit16_if.sv
// -----------------------------------------------------------------------------
// pc_unit16_if : request/response bundle of the program counter.
//   jump_addr, load, inc, call, ret : requests (master -> slave)
//   pc, stk_full, stk_empty, stk_err : registered state (slave -> master)
// -----------------------------------------------------------------------------
interface pc_unit16_if #(
   parameter int WIDTH = 16
) ();

   logic [WIDTH-1:0] jump_addr;
   logic             load;
   logic             inc;
   logic             call;
   logic             ret;
   logic [WIDTH-1:0] pc;
   logic             stk_full;
   logic             stk_empty;
   logic             stk_err;

   modport master (
      output jump_addr, load, inc, call, ret,
      input  pc, stk_full, stk_empty, stk_err
   );

   modport slave (
      input  jump_addr, load, inc, call, ret,
      output pc, stk_full, stk_empty, stk_err
   );

endinterface

// File: rtl/pc_unit16_ret_stack.sv
// -----------------------------------------------------------------------------
// ret_stack : parameterised LIFO holding return addresses.
//   clk, rst_n : clock, synchronous active-low reset (clears sp and flags)
//   push, din  : write din on top (ignored and flagged when full)
//   pop        : drop top entry (ignored and flagged when empty)
//   dout       : current top entry (valid while !empty)
//   full/empty : registered occupancy flags, updated together with sp
//   err        : sticky overflow/underflow flag, cleared only by reset
// pop wins when both are raised.
// -----------------------------------------------------------------------------
module ret_stack #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic             err
);

   localparam int AW  = $clog2(DEPTH);
   localparam int SPW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [SPW-1:0]   sp;
   logic [SPW-1:0]   sp_nxt;
   logic [SPW-1:0]   sp_m1;
   logic             do_push;
   logic             do_pop;
   logic             bad_op;

   assign do_pop  = pop && !empty;
   assign do_push = push && !pop && !full;
   assign bad_op  = (pop && empty) || (push && !pop && full);

   always_comb begin
      sp_nxt = sp;
      if (do_pop)       sp_nxt = sp - SPW'(1);
      else if (do_push) sp_nxt = sp + SPW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sp    <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
         err   <= 1'b0;
      end else begin
         sp    <= sp_nxt;
         full  <= (sp_nxt == SPW'(DEPTH));
         empty <= (sp_nxt == '0);
         if (bad_op) err <= 1'b1;
      end
   end

   // Storage has no reset; only sp decides which entries are meaningful.
   always_ff @(posedge clk) begin
      if (do_push) mem[sp[AW-1:0]] <= din;
   end

   assign sp_m1 = sp - SPW'(1);
   assign dout  = mem[sp_m1[AW-1:0]];

endmodule

// File: rtl/pc_unit16.sv
// -----------------------------------------------------------------------------
// pc_unit16 : 16-bit program counter with optional return-address stack.
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset, wins over any request
//   bus    : pc_unit16_if.slave (jump_addr/load/inc/call/ret in,
//            pc/stk_full/stk_empty/stk_err out, all outputs registered)
// Build option LVM_PC_STACK_EN: when defined the return stack is built and
// call/ret are honoured; otherwise call/ret are ignored and the flags read
// full=0, empty=1, err=0.
// -----------------------------------------------------------------------------
module pc_unit16
   import lvm_pkg::*;
#(
   parameter int               WIDTH     = LVM_WIDTH,
   parameter int               DEPTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VEC = LVM_RESET_VEC
) (
   input logic          clk,
   input logic          rst_n,
   pc_unit16_if.slave   bus
);

   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] pc_nxt;
   logic [WIDTH-1:0] pc_inc;
   logic [WIDTH-1:0] stk_dout;
   logic             stk_full;
   logic             stk_empty;
   logic             stk_err;
   pc_op_e           op;

`ifdef LVM_PC_STACK_EN
   localparam bit STK_EN = 1'b1;

   ret_stack #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_stk (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (op == PC_CALL),
      .pop   (op == PC_RET),
      .din   (pc_inc),
      .dout  (stk_dout),
      .full  (stk_full),
      .empty (stk_empty),
      .err   (stk_err)
   );
`else
   localparam bit STK_EN = 1'b0;

   logic unused_stk_req;

   assign unused_stk_req = &{1'b0, bus.call, bus.ret};
   assign stk_dout  = '0;
   assign stk_full  = 1'b0;
   assign stk_empty = 1'b1;
   assign stk_err   = 1'b0;
`endif

   assign op     = pc_decode(bus.ret, bus.call, bus.load, bus.inc, STK_EN);
   assign pc_inc = pc_q + WIDTH'(1);   // wraps modulo 2^WIDTH

   // Rejected call/ret (full/empty) leave the pc where it is.
   always_comb begin
      pc_nxt = pc_q;
      unique case (op)
         PC_RET:  if (!stk_empty) pc_nxt = stk_dout;
         PC_CALL: if (!stk_full)  pc_nxt = bus.jump_addr;
         PC_LOAD: pc_nxt = bus.jump_addr;
         PC_INC:  pc_nxt = pc_inc;
         default: pc_nxt = pc_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) pc_q <= RESET_VEC;
      else        pc_q <= pc_nxt;
   end

   assign bus.pc        = pc_q;
   assign bus.stk_full  = stk_full;
   assign bus.stk_empty = stk_empty;
   assign bus.stk_err   = stk_err;

endmodule

// File: tb/tb_pc_unit16.sv
// -----------------------------------------------------------------------------
// tb_pc_unit16 : self-checking bench for pc_unit16. A queue-based reference
// model follows the request rules; directed sequences from the test plan are
// followed by biased random traffic. Works with or without LVM_PC_STACK_EN.
// -----------------------------------------------------------------------------
module tb_pc_unit16;

   localparam int          DEPTH = 8;
   localparam logic [15:0] RV    = 16'h0000;
`ifdef LVM_PC_STACK_EN
   localparam bit STK = 1'b1;
`else
   localparam bit STK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pc_unit16_if #(.WIDTH(16)) bus ();

   pc_unit16 #(.WIDTH(16), .DEPTH(DEPTH), .RESET_VEC(RV)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // reference model state
   logic [15:0] m_pc;
   logic [15:0] m_stk[$];
   logic        m_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Drive one cycle of requests, advance the model at the edge, then
   // compare every output at the following falling edge.
   task automatic step(input logic r, input logic c, input logic l, input logic i,
                       input logic [15:0] a, input logic rn);
      bus.ret = r; bus.call = c; bus.load = l; bus.inc = i; bus.jump_addr = a;
      rst_n = rn;
      @(posedge clk);
      if (!rn) begin
         m_pc = RV;
         m_stk.delete();
         m_err = 1'b0;
      end else if (STK && r) begin
         if (m_stk.size() > 0) m_pc = m_stk.pop_back();
         else m_err = 1'b1;
      end else if (STK && c) begin
         if (m_stk.size() < DEPTH) begin
            m_stk.push_back(m_pc + 16'd1);
            m_pc = a;
         end else m_err = 1'b1;
      end else if (l) m_pc = a;
      else if (i) m_pc = m_pc + 16'd1;
      @(negedge clk);
      chk("pc",    32'(bus.pc),        32'(m_pc));
      chk("full",  32'(bus.stk_full),  32'(STK && m_stk.size() == DEPTH));
      chk("empty", 32'(bus.stk_empty), 32'(m_stk.size() == 0));
      chk("err",   32'(bus.stk_err),   32'(m_err));
   endtask

   task automatic hold();            step(0, 0, 0, 0, 16'h0, 1); endtask
   task automatic do_reset();        step(0, 0, 0, 0, 16'h0, 0); endtask
   task automatic do_inc();          step(0, 0, 0, 1, 16'h0, 1); endtask
   task automatic do_load(input logic [15:0] a); step(0, 0, 1, 0, a, 1); endtask
   task automatic do_call(input logic [15:0] a); step(0, 1, 0, 0, a, 1); endtask
   task automatic do_ret();          step(1, 0, 0, 0, 16'h0, 1); endtask

   initial begin
      bus.ret = 0; bus.call = 0; bus.load = 0; bus.inc = 0; bus.jump_addr = '0;
      rst_n = 0;
      m_pc = RV; m_err = 0;
      @(negedge clk);
      do_reset();
      chk("rst_pc",    32'(bus.pc), 32'h0);
      chk("rst_empty", 32'(bus.stk_empty), 32'h1);

      // sequential increments
      repeat (3) do_inc();
      chk("inc3_pc", 32'(bus.pc), 32'h3);

      // wrap
      do_load(16'hFFFF);
      chk("wrap_load", 32'(bus.pc), 32'hFFFF);
      do_inc();
      chk("wrap_inc", 32'(bus.pc), 32'h0);
      chk("wrap_err", 32'(bus.stk_err), 32'h0);

      // nested calls and returns
      do_load(16'h0010);
      do_call(16'h0100);
      do_call(16'h0200);
      do_ret();
      do_ret();

      // overflow: nine calls, then one ret
      do_reset();
      for (int k = 0; k < 9; k++) do_call(16'h1000 + 16'(k));
      do_ret();

      // underflow from reset, then priority combinations
      do_reset();
      do_ret();
      step(0, 1, 1, 1, 16'h0300, 1);   // call+load+inc
      step(1, 1, 0, 0, 16'h0400, 1);   // ret+call
      hold();

      // mid-operation reset together with a call
      do_reset();
      repeat (3) do_call(16'h0500);
      step(0, 1, 0, 0, 16'h0600, 0);
      chk("midrst_pc",  32'(bus.pc), 32'(RV));
      chk("midrst_err", 32'(bus.stk_err), 32'h0);

      // random traffic; occasional reset, ret/call biased so the stack moves
      for (int k = 0; k < 400; k++) begin
         logic [15:0] a;
         a = 16'($urandom);
         if ($urandom_range(9) == 0) a = 16'hFFFF;
         step(($urandom_range(3) == 0), ($urandom_range(2) == 0),
              ($urandom_range(3) == 0), ($urandom_range(1) == 0),
              a, ($urandom_range(60) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
